sha1_dict_feeder: RTL

- Drives dictionary SHA-1 digests into the `compare_sha1` comparator and reads back its `ans` result.
- Scans a synchronous-read dictionary memory entry by entry and stops on the first match.
- Reports the matching index, or reports not-found after `num_entries` entries.
- Sits between the dictionary memory and `compare_sha1`.

---
 rtl/sha1_dict_feeder_if.sv | 26 ++
 rtl/sha1_dict_feeder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sha1_dict_feeder_if.sv
// rtl/sha1_dict_feeder_if.sv - dictionary memory read port and compare_sha1 digest/answer bundle
interface sha1_dict_feeder_if #(
  parameter int ADDR_W = 10
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [159:0]      mem_rdata;
  logic [160:0]      dic;
  logic              cmp_ans;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_rdata,
    output dic,
    input  cmp_ans
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_rdata,
    input  dic,
    output cmp_ans
  );
endinterface

// File: rtl/sha1_dict_feeder.sv
// rtl/sha1_dict_feeder.sv - scans dictionary digests into compare_sha1, stops on first match
// Optional SHA1_FEEDER_FIND_ALL_EN: scan every entry and count matches on match_count.
module sha1_dict_feeder #(
  parameter int ADDR_W  = 10,
  parameter int CMP_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     num_entries,
  sha1_dict_feeder_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                found,
`ifdef SHA1_FEEDER_FIND_ALL_EN
  output logic [ADDR_W:0]     match_count,
`endif
  output logic [ADDR_W-1:0]   match_idx
);

  localparam int WC_W = (CMP_LAT < 2) ? 1 : $clog2(CMP_LAT + 1);
  localparam int unsigned DEPTH_I = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH = DEPTH_I[ADDR_W:0];

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LOAD = 3'd2,
    WAIT = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   limit;
  logic [ADDR_W:0]   lim_in;
  logic [WC_W-1:0]   wait_cnt;
  logic [159:0]      dic_q;
  logic              found_q;
  logic [ADDR_W-1:0] match_idx_q;
  logic              last;
  logic              start_ok;

  // Request beyond the memory depth is clamped so idx never wraps.
  assign lim_in   = (num_entries > DEPTH) ? DEPTH : num_entries;
  assign last     = ({1'b0, idx} == (limit - 1'b1));
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_n = (lim_in == '0) ? DONE : RD;
        end
      end
      RD:   state_n = LOAD;
      LOAD: state_n = WAIT;
      WAIT: begin
        if (wait_cnt <= WC_W'(1)) begin
          state_n = CHK;
        end
      end
      CHK: begin
`ifdef SHA1_FEEDER_FIND_ALL_EN
        state_n = last ? DONE : RD;
`else
        state_n = (bus.cmp_ans || last) ? DONE : RD;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      limit       <= '0;
      wait_cnt    <= '0;
      dic_q       <= '0;
      found_q     <= 1'b0;
      match_idx_q <= '0;
`ifdef SHA1_FEEDER_FIND_ALL_EN
      match_count <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            limit   <= lim_in;
            idx     <= '0;
            found_q <= 1'b0;
`ifdef SHA1_FEEDER_FIND_ALL_EN
            match_count <= '0;
`endif
          end
        end
        LOAD: begin
          dic_q    <= bus.mem_rdata;
          wait_cnt <= WC_W'(CMP_LAT);
        end
        WAIT: begin
          if (wait_cnt > WC_W'(1)) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        CHK: begin
`ifdef SHA1_FEEDER_FIND_ALL_EN
          if (bus.cmp_ans) begin
            found_q     <= 1'b1;
            match_count <= match_count + 1'b1;
            if (!found_q) begin
              match_idx_q <= idx;
            end
          end
          if (!last) begin
            idx <= idx + 1'b1;
          end
`else
          if (bus.cmp_ans) begin
            found_q     <= 1'b1;
            match_idx_q <= idx;
          end else if (!last) begin
            idx <= idx + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en   = (state == RD);
  assign bus.mem_addr = idx;
  assign bus.dic      = {1'b0, dic_q};
  assign busy         = (state == RD) || (state == LOAD) || (state == WAIT) || (state == CHK);
  assign done         = (state == DONE);
  assign found        = found_q;
  assign match_idx    = match_idx_q;

endmodule
